// File: rtl/instruction_fetch_if.sv
//------------------------------------------------------------------------------
// instruction_fetch_if
// Bundles the three buses around the fetch stage:
//   memory read port : mem_addr, mem_rd (out of fetch), mem_rdata, mem_ready (in)
//   redirect         : pc_load, pc_load_addr (in)
//   decoder handshake: instr_valid, instruction, operand, instr_len, instr_pc (out),
//                      instr_ready (in)
// Modport master is the fetch stage; modport slave is its environment
// (memory, execute stage and decoder).
//------------------------------------------------------------------------------
interface instruction_fetch_if;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic        mem_ready;
   logic        pc_load;
   logic [15:0] pc_load_addr;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  instruction;
   logic [15:0] operand;
   logic [1:0]  instr_len;
   logic [15:0] instr_pc;

   modport master (
      output mem_addr, mem_rd, instr_valid, instruction, operand, instr_len, instr_pc,
      input  mem_rdata, mem_ready, pc_load, pc_load_addr, instr_ready
   );

   modport slave (
      input  mem_addr, mem_rd, instr_valid, instruction, operand, instr_len, instr_pc,
      output mem_rdata, mem_ready, pc_load, pc_load_addr, instr_ready
   );
endinterface

// File: rtl/instruction_fetch.sv
//------------------------------------------------------------------------------
// instruction_fetch
// Front end of the 6502 decoder. Owns the 16-bit PC, optionally loads it from
// the reset vector, fetches opcode plus 0-2 operand bytes one byte per read and
// presents the complete instruction to the decoder with valid/ready.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - instruction_fetch_if.master (memory port, redirect, decoder bundle)
//------------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [15:0] RESET_VEC_ADDR = 16'hFFFC,
   parameter bit          USE_VECTOR     = 1'b1,
   parameter logic [15:0] START_PC       = 16'h0000
) (
   input  logic                  clk,
   input  logic                  rst,
   instruction_fetch_if.master   bus
);

   typedef enum logic [2:0] {
      VEC_LO, VEC_HI, OP, OPR_LO, OPR_HI, HOLD
   } state_t;

   localparam state_t RESET_STATE = USE_VECTOR ? VEC_LO : OP;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  instruction_q, instruction_d;
   logic [15:0] operand_q, operand_d;
   logic [1:0]  len_q, len_d;
   logic [15:0] instr_pc_q, instr_pc_d;

   logic        rd_req;
   logic        rd_done;
   logic [15:0] rd_addr;
   logic        redirect;

   // Instruction length from the opcode alone; 1-byte cases win over the rest.
   function automatic logic [1:0] opcode_len(input logic [7:0] o);
      if (o[3:0] == 4'h8 || o[3:0] == 4'hA || o == 8'h00 || o == 8'h40 || o == 8'h60)
         return 2'd1;
      else if (o[3:2] == 2'b11 || o == 8'h20 || ((o[3:0] == 4'h9 || o[3:0] == 4'hB) && o[4]))
         return 2'd3;
      else
         return 2'd2;
   endfunction

   assign rd_req   = (state_q != HOLD);
   assign rd_done  = rd_req && bus.mem_ready;
   // Redirects are ignored while the vector is still being loaded.
   assign redirect = bus.pc_load && (state_q != VEC_LO) && (state_q != VEC_HI);

   always_comb begin
      unique case (state_q)
         VEC_LO:  rd_addr = RESET_VEC_ADDR;
         VEC_HI:  rd_addr = RESET_VEC_ADDR + 16'd1;
         default: rd_addr = pc_q;
      endcase
   end

   // Outputs read as zero while reset is asserted, including the read strobe.
   assign bus.mem_rd      = rd_req && !rst;
   assign bus.mem_addr    = rst ? 16'h0000 : rd_addr;
   assign bus.instr_valid = (state_q == HOLD) && !rst;
   assign bus.instruction = instruction_q;
   assign bus.operand     = operand_q;
   assign bus.instr_len   = len_q;
   assign bus.instr_pc    = instr_pc_q;

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instruction_d = instruction_q;
      operand_d     = operand_q;
      len_d         = len_q;
      instr_pc_d    = instr_pc_q;

      if (redirect) begin
         // Drops any in-flight read and any bundle waiting in HOLD.
         state_d = OP;
         pc_d    = bus.pc_load_addr;
      end else begin
         unique case (state_q)
            VEC_LO: if (rd_done) begin
               pc_d[7:0] = bus.mem_rdata;
               state_d   = VEC_HI;
            end
            VEC_HI: if (rd_done) begin
               pc_d[15:8] = bus.mem_rdata;
               state_d    = OP;
            end
            OP: if (rd_done) begin
               instruction_d = bus.mem_rdata;
               instr_pc_d    = pc_q;
               operand_d     = 16'h0000;
               len_d         = opcode_len(bus.mem_rdata);
               pc_d          = pc_q + 16'd1;
               state_d       = (opcode_len(bus.mem_rdata) == 2'd1) ? HOLD : OPR_LO;
            end
            OPR_LO: if (rd_done) begin
               operand_d[7:0] = bus.mem_rdata;
               pc_d           = pc_q + 16'd1;
               state_d        = (len_q == 2'd2) ? HOLD : OPR_HI;
            end
            OPR_HI: if (rd_done) begin
               operand_d[15:8] = bus.mem_rdata;
               pc_d            = pc_q + 16'd1;
               state_d         = HOLD;
            end
            HOLD: if (bus.instr_ready) state_d = OP;
            default: state_d = RESET_STATE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RESET_STATE;
         pc_q          <= START_PC;
         instruction_q <= 8'h00;
         operand_q     <= 16'h0000;
         len_q         <= 2'd0;
         instr_pc_q    <= 16'h0000;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instruction_q <= instruction_d;
         operand_q     <= operand_d;
         len_q         <= len_d;
         instr_pc_q    <= instr_pc_d;
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
//------------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch: a 64 KiB byte memory answers reads
// combinationally; each task drives one scenario and checks outputs 1 time
// unit after the rising edge.
//------------------------------------------------------------------------------
module tb_instruction_fetch;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [7:0] mem [0:65535];

   instruction_fetch_if bus ();

   instruction_fetch #(
      .RESET_VEC_ADDR(16'hFFFC),
      .USE_VECTOR    (1'b1),
      .START_PC      (16'h0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.mem_rdata = mem[bus.mem_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.mem_rd !== 1'b0 || bus.instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobes: mem_rd=%b instr_valid=%b expected 0 0", bus.mem_rd, bus.instr_valid);
      end
      chk16("reset_mem_addr", bus.mem_addr, 16'h0000);
      chk16("reset_instruction", {8'h00, bus.instruction}, 16'h0000);
      chk16("reset_operand", bus.operand, 16'h0000);
      chk16("reset_len", {14'd0, bus.instr_len}, 16'h0000);
      chk16("reset_instr_pc", bus.instr_pc, 16'h0000);
      rst = 1'b0;
      #1;
      chk16("vec_lo_addr", bus.mem_addr, 16'hFFFC);
      checks++;
      if (bus.mem_rd !== 1'b1) begin
         errors++;
         $display("FAIL vec_lo_rd: got %b expected 1", bus.mem_rd);
      end
      tick();
      chk16("vec_hi_addr", bus.mem_addr, 16'hFFFD);
      tick();
      chk16("first_op_addr", bus.mem_addr, 16'h1234);
   endtask

   task automatic test_two_byte();
      bus.instr_ready = 1'b1;
      tick();
      chk16("lda_opr_addr", bus.mem_addr, 16'h1235);
      checks++;
      if (bus.instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL lda_early_valid: got %b expected 0", bus.instr_valid);
      end
      tick();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.mem_rd !== 1'b0) begin
         errors++;
         $display("FAIL lda_valid: valid=%b mem_rd=%b expected 1 0", bus.instr_valid, bus.mem_rd);
      end
      chk16("lda_instruction", {8'h00, bus.instruction}, 16'h00A9);
      chk16("lda_operand", bus.operand, 16'h0005);
      chk16("lda_len", {14'd0, bus.instr_len}, 16'd2);
      chk16("lda_instr_pc", bus.instr_pc, 16'h1234);
      tick();
      chk16("next_op_addr", bus.mem_addr, 16'h1236);
      checks++;
      if (bus.instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL valid_falls: got %b expected 0", bus.instr_valid);
      end
   endtask

   task automatic test_hold_stall();
      bus.instr_ready = 1'b0;
      tick();
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.instr_valid !== 1'b1 || bus.instruction !== 8'h4C || bus.operand !== 16'h8000 ||
             bus.instr_len !== 2'd3 || bus.instr_pc !== 16'h1236) begin
            errors++;
            $display("FAIL jmp_hold[%0d]: got v=%b {%h,%h,%0d,%h} expected v=1 {4c,8000,3,1236}",
                     i, bus.instr_valid, bus.instruction, bus.operand, bus.instr_len, bus.instr_pc);
         end
         if (i < 3) tick();
      end
      bus.instr_ready = 1'b1;
      tick();
      chk16("after_jmp_addr", bus.mem_addr, 16'h1239);
   endtask

   task automatic test_wrap();
      bus.pc_load      = 1'b1;
      bus.pc_load_addr = 16'hFFFF;
      tick();
      bus.pc_load = 1'b0;
      chk16("wrap_op_addr", bus.mem_addr, 16'hFFFF);
      tick();
      chk16("wrap_instruction", {8'h00, bus.instruction}, 16'h00EA);
      chk16("wrap_len", {14'd0, bus.instr_len}, 16'd1);
      chk16("wrap_instr_pc", bus.instr_pc, 16'hFFFF);
      chk16("wrap_operand", bus.operand, 16'h0000);
      tick();
      chk16("wrap_next_addr", bus.mem_addr, 16'h0000);
   endtask

   task automatic test_redirect();
      tick();
      chk16("redir_opr_addr", bus.mem_addr, 16'h0001);
      bus.pc_load      = 1'b1;
      bus.pc_load_addr = 16'hC000;
      tick();
      bus.pc_load = 1'b0;
      chk16("redir_target_addr", bus.mem_addr, 16'hC000);
      checks++;
      if (bus.instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_valid: got %b expected 0", bus.instr_valid);
      end
      tick();
      tick();
      checks++;
      if (bus.instr_valid !== 1'b1) begin
         errors++;
         $display("FAIL redir_bundle_valid: got %b expected 1", bus.instr_valid);
      end
      chk16("redir_instruction", {8'h00, bus.instruction}, 16'h00A2);
      chk16("redir_operand", bus.operand, 16'h0011);
      chk16("redir_instr_pc", bus.instr_pc, 16'hC000);
      // Redirect in HOLD wins over a coincident accept.
      bus.pc_load      = 1'b1;
      bus.pc_load_addr = 16'h2000;
      tick();
      bus.pc_load = 1'b0;
      chk16("hold_redir_addr", bus.mem_addr, 16'h2000);
      checks++;
      if (bus.instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_redir_valid: got %b expected 0", bus.instr_valid);
      end
   endtask

   task automatic test_mem_stall();
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h2000 || bus.instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall[%0d]: rd=%b addr=%h valid=%b expected 1 2000 0",
                     i, bus.mem_rd, bus.mem_addr, bus.instr_valid);
         end
      end
      bus.mem_ready = 1'b1;
      tick();
      chk16("stall_opr_lo_addr", bus.mem_addr, 16'h2001);
      tick();
      chk16("stall_opr_hi_addr", bus.mem_addr, 16'h2002);
      rst = 1'b1;
      tick();
      checks++;
      if (bus.mem_rd !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instruction !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset: rd=%b valid=%b instr=%h expected 0 0 00",
                  bus.mem_rd, bus.instr_valid, bus.instruction);
      end
      rst = 1'b0;
      #1;
      chk16("mid_reset_vec_addr", bus.mem_addr, 16'hFFFC);
   endtask

   task automatic test_vec_ignore();
      bus.pc_load      = 1'b1;
      bus.pc_load_addr = 16'h5555;
      tick();
      chk16("vec_ignore_lo", bus.mem_addr, 16'hFFFD);
      tick();
      bus.pc_load = 1'b0;
      chk16("vec_ignore_hi", bus.mem_addr, 16'h1234);
   endtask

   task automatic test_len_table();
      logic [7:0]  ops  [10] = '{8'h00, 8'h20, 8'h19, 8'h60, 8'h09, 8'h1B, 8'h0A, 8'h30, 8'h8D, 8'h40};
      logic [1:0]  lens [10] = '{2'd1,  2'd3,  2'd3,  2'd1,  2'd2,  2'd3,  2'd1,  2'd2,  2'd3,  2'd1};
      logic [15:0] exp_opr;
      int          cycles;
      bus.instr_ready = 1'b0;
      mem[16'h3001] = 8'hAA;
      mem[16'h3002] = 8'hBB;
      for (int i = 0; i < 10; i++) begin
         mem[16'h3000]    = ops[i];
         bus.pc_load      = 1'b1;
         bus.pc_load_addr = 16'h3000;
         tick();
         bus.pc_load = 1'b0;
         cycles = 0;
         while (bus.instr_valid !== 1'b1 && cycles < 6) begin
            tick();
            cycles++;
         end
         exp_opr = (lens[i] == 2'd1) ? 16'h0000 : (lens[i] == 2'd2) ? 16'h00AA : 16'hBBAA;
         checks++;
         if (bus.instr_valid !== 1'b1 || bus.instr_len !== lens[i] || cycles != int'(lens[i]) ||
             bus.operand !== exp_opr) begin
            errors++;
            $display("FAIL len_%h: valid=%b len=%0d cycles=%0d operand=%h expected 1 %0d %0d %h",
                     ops[i], bus.instr_valid, bus.instr_len, cycles, bus.operand,
                     lens[i], lens[i], exp_opr);
         end
      end
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      rst              = 1'b1;
      bus.mem_ready    = 1'b1;
      bus.pc_load      = 1'b0;
      bus.pc_load_addr = 16'h0000;
      bus.instr_ready  = 1'b0;
      for (int a = 0; a < 65536; a++) mem[a] = 8'hEA;
      mem[16'hFFFC] = 8'h34;
      mem[16'hFFFD] = 8'h12;
      mem[16'h1234] = 8'hA9;
      mem[16'h1235] = 8'h05;
      mem[16'h1236] = 8'h4C;
      mem[16'h1237] = 8'h00;
      mem[16'h1238] = 8'h80;
      mem[16'hFFFF] = 8'hEA;
      mem[16'h0000] = 8'hA9;
      mem[16'h0001] = 8'h77;
      mem[16'hC000] = 8'hA2;
      mem[16'hC001] = 8'h11;
      mem[16'h2000] = 8'hAD;
      mem[16'h2001] = 8'h34;
      mem[16'h2002] = 8'h12;

      test_reset();
      test_two_byte();
      test_hold_stall();
      test_wrap();
      test_redirect();
      test_mem_stall();
      test_vec_ignore();
      test_len_table();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
